// File: rtl/tile_writer_if.sv
// Command bus of the tile writer: a valid/ready handshake carrying one draw command.
interface tile_writer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_x;
    logic [4:0] cmd_y;
    logic [5:0] cmd_w;
    logic [4:0] cmd_h;
    logic [7:0] cmd_color;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready
    );
endinterface

// File: rtl/tile_writer.sv
// Tile buffer with a command engine (single write, clipped rect fill, clear)
// and an independent registered display read port.
module tile_writer #(
    parameter int unsigned HBLK        = 32,
    parameter int unsigned VBLK        = 24,
    parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
    input  logic               clk,
    input  logic               rst_n,
    tile_writer_if.slave       cmd_if,
    input  logic [15:0]        rd_addr,
    output logic [7:0]         rd_color,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned DEPTH  = HBLK * VBLK;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned XW     = 6;
    localparam int unsigned YW     = 5;
    localparam int unsigned SUM_W  = 7;

    localparam logic [SUM_W-1:0]  X_LIM   = SUM_W'(HBLK);
    localparam logic [SUM_W-1:0]  Y_LIM   = SUM_W'(VBLK);
    localparam logic [SUM_W-1:0]  X_MAX   = SUM_W'(HBLK - 1);
    localparam logic [SUM_W-1:0]  Y_MAX   = SUM_W'(VBLK - 1);
    localparam logic [ADDR_W-1:0] HBLK_A  = ADDR_W'(HBLK);
    localparam logic [15:0]       DEPTH_R = 16'(DEPTH);

    localparam logic [1:0] OP_SINGLE = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   cur_x_q, cur_x_d;
    logic [YW-1:0]   cur_y_q, cur_y_d;
    logic [XW-1:0]   x_start_q, x_start_d;
    logic [XW-1:0]   x_end_q, x_end_d;
    logic [YW-1:0]   y_end_q, y_end_d;
    logic [7:0]      color_q, color_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      rd_color_q, rd_color_d;

    logic [7:0]        mem [DEPTH];
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [SUM_W-1:0]  x_sum_c;
    logic [SUM_W-1:0]  y_sum_c;
    logic              out_of_range_c;

    // Clipping sums are 7 bits wide so x+w-1 never wraps before the clamp.
    always_comb begin
        x_sum_c        = SUM_W'(cmd_if.cmd_x) + SUM_W'(cmd_if.cmd_w) - SUM_W'(1);
        y_sum_c        = SUM_W'(cmd_if.cmd_y) + SUM_W'(cmd_if.cmd_h) - SUM_W'(1);
        out_of_range_c = (SUM_W'(cmd_if.cmd_x) >= X_LIM) ||
                         (SUM_W'(cmd_if.cmd_y) >= Y_LIM);
    end

    // Command sequencing and registered status outputs.
    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        x_start_d = x_start_q;
        x_end_d   = x_end_q;
        y_end_d   = y_end_q;
        color_d   = color_q;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_if.cmd_valid) begin
                    if (cmd_if.cmd_op == OP_CLEAR) begin
                        cur_x_d   = '0;
                        cur_y_d   = '0;
                        x_start_d = '0;
                        x_end_d   = XW'(X_MAX);
                        y_end_d   = YW'(Y_MAX);
                        color_d   = CLEAR_COLOR;
                        state_d   = RUN;
                    end else if (cmd_if.cmd_op == OP_SINGLE || cmd_if.cmd_op == OP_FILL) begin
                        if (out_of_range_c) begin
                            err_d = 1'b1;
                        end else begin
                            cur_x_d   = cmd_if.cmd_x;
                            cur_y_d   = cmd_if.cmd_y;
                            x_start_d = cmd_if.cmd_x;
                            color_d   = cmd_if.cmd_color;
                            if (cmd_if.cmd_op == OP_SINGLE) begin
                                x_end_d = cmd_if.cmd_x;
                                y_end_d = cmd_if.cmd_y;
                                state_d = RUN;
                            end else if (cmd_if.cmd_w == '0 || cmd_if.cmd_h == '0) begin
                                state_d = DONE;
                            end else begin
                                x_end_d = (x_sum_c > X_MAX) ? XW'(X_MAX) : XW'(x_sum_c);
                                y_end_d = (y_sum_c > Y_MAX) ? YW'(Y_MAX) : YW'(y_sum_c);
                                state_d = RUN;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Row-major walk over the clipped rectangle, one tile per cycle.
                if (cur_x_q == x_end_q) begin
                    if (cur_y_q == y_end_q) begin
                        state_d = DONE;
                    end else begin
                        cur_x_d = x_start_q;
                        cur_y_d = cur_y_q + YW'(1);
                    end
                end else begin
                    cur_x_d = cur_x_q + XW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // Write port: reset suppresses the write on the edge it is sampled.
    always_comb begin
        wr_en_c   = rst_n && (state_q == RUN);
        wr_addr_c = ADDR_W'(cur_y_q) * HBLK_A + ADDR_W'(cur_x_q);
    end

    always_comb begin
        rd_color_d = 8'h00;
        if (rd_addr < DEPTH_R) begin
            rd_color_d = mem[rd_addr[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            x_start_q   <= '0;
            x_end_q     <= '0;
            y_end_q     <= '0;
            color_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_color_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            x_start_q   <= x_start_d;
            x_end_q     <= x_end_d;
            y_end_q     <= y_end_d;
            color_q     <= color_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_color_q  <= rd_color_d;
        end
    end

    // Tile storage is deliberately outside reset; only the clear op wipes it.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= color_q;
        end
    end

    assign cmd_if.cmd_ready = cmd_ready_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;
    assign rd_color         = rd_color_q;

endmodule

// File: tb/tb_tile_writer.sv
// Self-checking bench for tile_writer: directed and random commands against a
// tile-list model of the buffer.
module tb_tile_writer;

    localparam int HB = 32;
    localparam int VB = 24;
    localparam int DEPTH = HB * VB;
    localparam logic [7:0] CLR = 8'h00;

    logic        clk;
    logic        rst_n;
    logic [15:0] rd_addr;
    logic [7:0]  rd_color;
    logic        busy;
    logic        done;
    logic        err;

    tile_writer_if bus ();

    tile_writer #(.HBLK(HB), .VBLK(VB), .CLEAR_COLOR(CLR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_if   (bus),
        .rd_addr  (rd_addr),
        .rd_color (rd_color),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_mem [DEPTH];
    bit         known [DEPTH];
    int         exp_q [$];
    logic [7:0] exp_col;
    bit         exp_rej;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected tile list for a command, straight from the geometric rules.
    task automatic build(input int op, input int x, input int y, input int w, input int h,
                         input logic [7:0] color);
        exp_q.delete();
        exp_rej = 1'b0;
        exp_col = color;
        if (op == 3) begin
            exp_rej = 1'b1;
        end else if (op == 2) begin
            exp_col = CLR;
            for (int a = 0; a < DEPTH; a++) exp_q.push_back(a);
        end else if (x >= HB || y >= VB) begin
            exp_rej = 1'b1;
        end else if (op == 0) begin
            exp_q.push_back(y * HB + x);
        end else if (w > 0 && h > 0) begin
            for (int yy = y; yy <= y + h - 1 && yy < VB; yy++)
                for (int xx = x; xx <= x + w - 1 && xx < HB; xx++)
                    exp_q.push_back(yy * HB + xx);
        end
    endtask

    task automatic scramble_cmd();
        bus.cmd_op    = 2'($urandom);
        bus.cmd_x     = 6'($urandom);
        bus.cmd_y     = 5'($urandom);
        bus.cmd_w     = 6'($urandom);
        bus.cmd_h     = 5'($urandom);
        bus.cmd_color = 8'($urandom);
    endtask

    // Issue one command; abort_at >= 0 pulses reset before that write cycle.
    task automatic run_cmd(input string tag, input int op, input int x, input int y,
                           input int w, input int h, input logic [7:0] color,
                           input int abort_at);
        build(op, x, y, w, h, color);
        bus.cmd_op    = 2'(op);
        bus.cmd_x     = 6'(x);
        bus.cmd_y     = 5'(y);
        bus.cmd_w     = 6'(w);
        bus.cmd_h     = 5'(h);
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
        chk({tag, ".ready_pre"}, 16'(bus.cmd_ready), 16'd1);
        tick();
        bus.cmd_valid = 1'b0;
        scramble_cmd();
        if (exp_rej) begin
            chk({tag, ".err"}, 16'(err), 16'd1);
            chk({tag, ".rej_ready"}, 16'(bus.cmd_ready), 16'd1);
            chk({tag, ".rej_busy"}, 16'(busy), 16'd0);
            chk({tag, ".rej_done"}, 16'(done), 16'd0);
            tick();
            chk({tag, ".err_clr"}, 16'(err), 16'd0);
            chk({tag, ".rej_ready2"}, 16'(bus.cmd_ready), 16'd1);
            return;
        end
        chk({tag, ".err0"}, 16'(err), 16'd0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk({tag, ".rst_ready"}, 16'(bus.cmd_ready), 16'd1);
                chk({tag, ".rst_busy"}, 16'(busy), 16'd0);
                chk({tag, ".rst_done"}, 16'(done), 16'd0);
                chk({tag, ".rst_rdc"}, 16'(rd_color), 16'd0);
                tick();
                chk({tag, ".rst_busy2"}, 16'(busy), 16'd0);
                chk({tag, ".rst_done2"}, 16'(done), 16'd0);
                for (int j = 0; j < k; j++) begin
                    model_mem[exp_q[j]] = exp_col;
                    known[exp_q[j]] = 1'b1;
                end
                return;
            end
            chk({tag, ".busy"}, 16'(busy), 16'd1);
            chk({tag, ".ready_lo"}, 16'(bus.cmd_ready), 16'd0);
            chk({tag, ".done_lo"}, 16'(done), 16'd0);
            rd_addr = 16'(exp_q[k]);
            tick();
            // Same-cycle read of the tile being written must show the old value.
            if (known[exp_q[k]]) chk({tag, ".rd_old"}, 16'(rd_color), 16'(model_mem[exp_q[k]]));
        end
        chk({tag, ".done"}, 16'(done), 16'd1);
        chk({tag, ".done_busy"}, 16'(busy), 16'd1);
        chk({tag, ".done_ready"}, 16'(bus.cmd_ready), 16'd0);
        tick();
        chk({tag, ".done_clr"}, 16'(done), 16'd0);
        chk({tag, ".ready_post"}, 16'(bus.cmd_ready), 16'd1);
        chk({tag, ".busy_post"}, 16'(busy), 16'd0);
        foreach (exp_q[i]) begin
            model_mem[exp_q[i]] = exp_col;
            known[exp_q[i]] = 1'b1;
        end
    endtask

    task automatic read_one(input string tag, input int a);
        rd_addr = 16'(a);
        tick();
        if (a < DEPTH && !known[a]) return;
        chk(tag, 16'(rd_color), (a < DEPTH) ? 16'(model_mem[a]) : 16'd0);
    endtask

    task automatic readback(input string tag);
        for (int a = 0; a < DEPTH; a++) read_one(tag, a);
    endtask

    initial begin
        int op;
        foreach (known[i]) known[i] = 1'b0;
        rst_n = 1'b0;
        rd_addr = '0;
        bus.cmd_valid = 1'b0;
        scramble_cmd();
        tick();
        tick();
        chk("reset.ready", 16'(bus.cmd_ready), 16'd1);
        chk("reset.busy", 16'(busy), 16'd0);
        chk("reset.done", 16'(done), 16'd0);
        chk("reset.err", 16'(err), 16'd0);
        chk("reset.rdc", 16'(rd_color), 16'd0);
        rst_n = 1'b1;
        tick();

        run_cmd("clear0", 2, 0, 0, 0, 0, 8'hAA, -1);
        readback("rb_clear0");

        run_cmd("single", 0, 5, 3, 0, 0, 8'hE0, -1);
        read_one("rd101", 101);

        run_cmd("fill_clip", 1, 30, 22, 4, 4, 8'h03, -1);
        for (int a = 733; a < DEPTH; a++) read_one("rd_clip", a);

        run_cmd("rej_x32", 0, 32, 0, 1, 1, 8'h11, -1);
        run_cmd("rej_op3", 3, 1, 1, 1, 1, 8'h22, -1);
        run_cmd("rej_y24", 1, 0, 24, 2, 2, 8'h33, -1);
        run_cmd("fill_w0", 1, 4, 4, 0, 3, 8'h44, -1);
        run_cmd("fill_h0", 1, 4, 4, 3, 0, 8'h45, -1);
        run_cmd("row40", 1, 0, 1, 32, 1, 8'h3C, -1);
        read_one("rd40_new", 40);
        read_one("rd800", 800);

        for (int n = 0; n < 10; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 1));
            run_cmd("rand", op, int'($urandom_range(0, 35)), int'($urandom_range(0, 26)),
                    int'($urandom_range(0, 32)), int'($urandom_range(0, 24)),
                    8'($urandom), -1);
        end
        readback("rb_rand");

        run_cmd("clear1", 2, 7, 7, 7, 7, 8'h77, -1);
        readback("rb_clear1");

        run_cmd("fill_all", 1, 0, 0, 32, 24, 8'hFF, -1);
        run_cmd("clear_abort", 2, 0, 0, 0, 0, 8'h00, 300);
        readback("rb_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
